// File: rtl/mod_swapchain_pkg.sv
// Shared types for the modulation segment swap controller.
package mod_swapchain_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        INFINITE   = 2'd0,
        WAIT_START = 2'd1,
        LOOPING    = 2'd2,
        STOPPED    = 2'd3
    } swapchain_state_t;

    // Transition trigger codes as written by the register file.
    typedef enum logic [7:0] {
        TRANSITION_MODE_SYNC_IDX = 8'h00,
        TRANSITION_MODE_SYS_TIME = 8'h01,
        TRANSITION_MODE_GPIO     = 8'h02,
        TRANSITION_MODE_EXT      = 8'hF0
    } transition_mode_t;

    // Repeat value meaning "play forever".
    localparam logic [15:0] RepInfinite = 16'hFFFF;

endpackage

// File: rtl/swapchain_wrap_detect.sv
// Per-segment wrap detector: flags the cycle where the index returns from
// its last value to zero.
module swapchain_wrap_detect #(
    parameter int IdxWidth = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IdxWidth-1:0] idx,
    input  logic [IdxWidth-1:0] cycle,
    output logic                wrap
);

    logic [IdxWidth-1:0] idx_prev;

    // Remember last cycle's index so the CYCLE->0 step can be seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idx_prev <= '0;
        else     idx_prev <= idx;
    end

    // A cycle of 0 makes every cycle a wrap, which falls out naturally here.
    assign wrap = (idx == '0) && (idx_prev == cycle);

endmodule

// File: rtl/mod_swapchain.sv
// Modulation segment swap controller: decides when the sampler switches
// segment and when a finite-repeat segment stops.
module mod_swapchain
    import mod_swapchain_pkg::*;
#(
    parameter int NumSegment = 2,
    parameter int IdxWidth   = 15
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                UPDATE_SETTINGS,
    input  logic                                REQ_RD_SEGMENT,
    input  logic [15:0]                         REP,
    input  logic [7:0]                          TRANSITION_MODE,
    input  logic [63:0]                         TRANSITION_VALUE,
    input  logic [55:0]                         SYS_TIME,
    input  logic [3:0]                          GPIO_IN,
    input  logic [NumSegment-1:0][IdxWidth-1:0] CYCLE,
    input  logic [NumSegment-1:0][IdxWidth-1:0] IDX,
    output logic                                SEGMENT,
    output logic                                STOP,
    output logic                                BUSY
);

    swapchain_state_t state_q, state_d;
    logic             seg_q, seg_d;
    logic             stop_q, stop_d;
    logic             req_seg_q, req_seg_d;
    logic [15:0]      rep_q, rep_d;
    logic [7:0]       mode_q, mode_d;
    logic [55:0]      tval_q, tval_d;
    logic [15:0]      loop_cnt_q, loop_cnt_d;
    logic [3:0]       gpio_prev_q;
    logic [NumSegment-1:0] wrap;
    logic             start_hit;

    // Only the time/pin field of the transition value is meaningful.
    logic unused_tval;
    assign unused_tval = ^TRANSITION_VALUE[63:56];

    genvar s;
    generate
        for (s = 0; s < NumSegment; s++) begin : g_wrap
            swapchain_wrap_detect #(
                .IdxWidth(IdxWidth)
            ) u_wrap (
                .clk  (CLK),
                .rst  (RST),
                .idx  (IDX[s]),
                .cycle(CYCLE[s]),
                .wrap (wrap[s])
            );
        end
    endgenerate

    // Previous GPIO sample for rising-edge triggers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) gpio_prev_q <= '0;
        else     gpio_prev_q <= GPIO_IN;
    end

    // Start condition for a pending request, chosen by the latched mode.
    always_comb begin
        start_hit = 1'b0;
        case (mode_q)
            TRANSITION_MODE_SYS_TIME: start_hit = (SYS_TIME >= tval_q);
            TRANSITION_MODE_GPIO:     start_hit = GPIO_IN[tval_q[1:0]] & ~gpio_prev_q[tval_q[1:0]];
            TRANSITION_MODE_EXT:      start_hit = wrap[seg_q];
            default:                  start_hit = wrap[req_seg_q];
        endcase
    end

    // Next-state logic; a settings update overrides anything in flight.
    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        stop_d     = stop_q;
        req_seg_d  = req_seg_q;
        rep_d      = rep_q;
        mode_d     = mode_q;
        tval_d     = tval_q;
        loop_cnt_d = loop_cnt_q;
        if (UPDATE_SETTINGS) begin
            req_seg_d = REQ_RD_SEGMENT;
            rep_d     = REP;
            mode_d    = TRANSITION_MODE;
            tval_d    = TRANSITION_VALUE[55:0];
            if (REP == RepInfinite) begin
                seg_d   = REQ_RD_SEGMENT;
                stop_d  = 1'b0;
                state_d = INFINITE;
            end else begin
                state_d = WAIT_START;
            end
        end else begin
            case (state_q)
                WAIT_START: begin
                    if (start_hit) begin
                        seg_d      = req_seg_q;
                        stop_d     = 1'b0;
                        loop_cnt_d = '0;
                        state_d    = LOOPING;
                    end
                end
                LOOPING: begin
                    if (wrap[seg_q]) begin
                        if (loop_cnt_q == rep_q) begin
                            stop_d  = 1'b1;
                            state_d = STOPPED;
                        end else begin
                            loop_cnt_d = loop_cnt_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and latched-settings registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= INFINITE;
            seg_q      <= 1'b0;
            stop_q     <= 1'b0;
            req_seg_q  <= 1'b0;
            rep_q      <= '0;
            mode_q     <= '0;
            tval_q     <= '0;
            loop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            stop_q     <= stop_d;
            req_seg_q  <= req_seg_d;
            rep_q      <= rep_d;
            mode_q     <= mode_d;
            tval_q     <= tval_d;
            loop_cnt_q <= loop_cnt_d;
        end
    end

    assign SEGMENT = seg_q;
    assign STOP    = stop_q;
    assign BUSY    = (state_q == WAIT_START);

endmodule

// File: tb/tb_mod_swapchain.sv
// Bench for mod_swapchain: directed vector table, reset corner, then random
// traffic checked against a loop-countdown reference model.
module tb_mod_swapchain;

    localparam int IW = 15;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              UPDATE_SETTINGS = 1'b0;
    logic              REQ_RD_SEGMENT = 1'b0;
    logic [15:0]       REP = '0;
    logic [7:0]        TRANSITION_MODE = '0;
    logic [63:0]       TRANSITION_VALUE = '0;
    logic [55:0]       SYS_TIME = '0;
    logic [3:0]        GPIO_IN = '0;
    logic [1:0][IW-1:0] CYCLE;
    logic [1:0][IW-1:0] IDX;
    logic              SEGMENT, STOP, BUSY;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mod_swapchain #(.NumSegment(2), .IdxWidth(IW)) dut (
        .CLK(CLK), .RST(RST), .UPDATE_SETTINGS(UPDATE_SETTINGS),
        .REQ_RD_SEGMENT(REQ_RD_SEGMENT), .REP(REP),
        .TRANSITION_MODE(TRANSITION_MODE), .TRANSITION_VALUE(TRANSITION_VALUE),
        .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN), .CYCLE(CYCLE), .IDX(IDX),
        .SEGMENT(SEGMENT), .STOP(STOP), .BUSY(BUSY)
    );

    // Reference model: pending flag plus a count of wraps still to play.
    logic        m_seg, m_stop, m_pend, m_loop, m_req;
    logic [15:0] m_rep;
    logic [7:0]  m_mode;
    logic [63:0] m_val;
    int          m_left;
    logic [IW-1:0] m_pidx [2];
    logic [3:0]  m_pgpio;

    task automatic model_reset();
        m_seg = 0; m_stop = 0; m_pend = 0; m_loop = 0; m_req = 0;
        m_rep = '0; m_mode = '0; m_val = '0; m_left = 0;
        m_pidx[0] = '0; m_pidx[1] = '0; m_pgpio = '0;
    endtask

    task automatic model_step();
        logic w [2];
        logic hit;
        hit = 1'b0;
        for (int s = 0; s < 2; s++) w[s] = (IDX[s] == '0) && (m_pidx[s] == CYCLE[s]);
        if (UPDATE_SETTINGS) begin
            m_req = REQ_RD_SEGMENT; m_rep = REP; m_mode = TRANSITION_MODE;
            m_val = TRANSITION_VALUE; m_loop = 1'b0;
            if (REP == 16'hFFFF) begin
                m_seg = REQ_RD_SEGMENT; m_stop = 1'b0; m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
            end
        end else if (m_pend) begin
            if (m_mode == 8'h01)      hit = (SYS_TIME >= m_val[55:0]);
            else if (m_mode == 8'h02) hit = GPIO_IN[m_val[1:0]] && !m_pgpio[m_val[1:0]];
            else if (m_mode == 8'hF0) hit = w[m_seg];
            else                      hit = w[m_req];
            if (hit) begin
                m_seg = m_req; m_stop = 1'b0; m_pend = 1'b0; m_loop = 1'b1;
                m_left = int'(m_rep) + 1;
            end
        end else if (m_loop && w[m_seg]) begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_stop = 1'b1; m_loop = 1'b0; end
        end
        for (int s = 0; s < 2; s++) m_pidx[s] = IDX[s];
        m_pgpio = GPIO_IN;
    endtask

    task automatic check(input string nm, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: seg/stop/busy got %b want %b", nm, got, exp);
        end
    endtask

    // One clock: advance the model on the applied inputs, then compare.
    task automatic cyc(input string nm);
        model_step();
        @(posedge CLK);
        #1;
        check(nm, {SEGMENT, STOP, BUSY}, {m_seg, m_stop, m_pend});
    endtask

    typedef struct {
        logic        upd;
        logic        req;
        logic [15:0] rep;
        logic [7:0]  mode;
        logic [63:0] val;
        logic [55:0] st;
        logic [3:0]  gpio;
        logic [IW-1:0] idx1;
        logic [2:0]  exp;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic upd, input logic req, input logic [15:0] rep,
                                input logic [7:0] mode, input logic [63:0] val,
                                input logic [55:0] st, input logic [3:0] gpio,
                                input logic [IW-1:0] idx1, input logic [2:0] exp);
        vec_t v;
        v.upd = upd; v.req = req; v.rep = rep; v.mode = mode; v.val = val;
        v.st = st; v.gpio = gpio; v.idx1 = idx1; v.exp = exp;
        return v;
    endfunction

    initial begin
        // CYCLE[0]=5 with IDX[0] parked at 2, so segment 0 never wraps here.
        CYCLE[0] = 15'd5; CYCLE[1] = 15'd3;
        IDX[0] = 15'd2;   IDX[1] = 15'd0;

        // Expected {SEGMENT,STOP,BUSY} after the edge that samples each row.
        vt.push_back(mk(1,1,16'hFFFF,8'h01,64'hFFFF_FFFF_FFFF_FFFF,0,0,0,3'b100)); // infinite switch
        vt.push_back(mk(1,0,16'hFFFF,8'h00,0,0,0,0,3'b000));
        vt.push_back(mk(1,1,16'd1,8'h00,0,0,0,1,3'b001));   // sync-idx request
        vt.push_back(mk(0,0,0,0,0,0,0,2,3'b001));
        vt.push_back(mk(0,0,0,0,0,0,0,3,3'b001));
        vt.push_back(mk(0,0,0,0,0,0,0,0,3'b100));           // 3->0 wrap starts
        vt.push_back(mk(0,0,0,0,0,0,0,1,3'b100));
        vt.push_back(mk(0,0,0,0,0,0,0,2,3'b100));
        vt.push_back(mk(0,0,0,0,0,0,0,3,3'b100));
        vt.push_back(mk(0,0,0,0,0,0,0,0,3'b100));           // first loop done
        vt.push_back(mk(0,0,0,0,0,0,0,1,3'b100));
        vt.push_back(mk(0,0,0,0,0,0,0,2,3'b100));
        vt.push_back(mk(0,0,0,0,0,0,0,3,3'b100));
        vt.push_back(mk(0,0,0,0,0,0,0,0,3'b110));           // second loop -> stop
        vt.push_back(mk(0,0,0,0,0,0,0,1,3'b110));
        vt.push_back(mk(1,0,16'hFFFF,8'h00,0,0,0,1,3'b000));
        vt.push_back(mk(1,1,16'd0,8'h01,64'd1000,990,0,1,3'b001)); // sys-time request
        vt.push_back(mk(0,0,0,0,0,995,0,1,3'b001));
        vt.push_back(mk(0,0,0,0,0,999,0,1,3'b001));
        vt.push_back(mk(0,0,0,0,0,1000,0,1,3'b100));
        vt.push_back(mk(0,0,0,0,0,1001,0,2,3'b100));
        vt.push_back(mk(0,0,0,0,0,1001,0,3,3'b100));
        vt.push_back(mk(0,0,0,0,0,1001,0,0,3'b110));        // REP=0 -> stop after one wrap
        vt.push_back(mk(1,0,16'hFFFF,8'h00,0,1001,0,0,3'b000));
        vt.push_back(mk(1,1,16'd5,8'h02,64'd2,1001,4'b0000,0,3'b001)); // gpio pin 2
        vt.push_back(mk(0,0,0,0,0,1001,4'b0010,0,3'b001));  // pin 1 ignored
        vt.push_back(mk(0,0,0,0,0,1001,4'b0000,0,3'b001));
        vt.push_back(mk(0,0,0,0,0,1001,4'b0100,0,3'b100));  // pin 2 rises
        vt.push_back(mk(0,0,0,0,0,1001,4'b0000,0,3'b100));
        vt.push_back(mk(1,0,16'hFFFF,8'h00,0,1001,0,0,3'b000));
        vt.push_back(mk(1,1,16'd0,8'h00,0,1001,0,0,3'b001)); // request then override
        vt.push_back(mk(0,0,0,0,0,1001,0,0,3'b001));
        vt.push_back(mk(1,0,16'hFFFF,8'h00,0,1001,0,0,3'b000));
        vt.push_back(mk(0,0,0,0,0,1001,0,1,3'b000));
        vt.push_back(mk(0,0,0,0,0,1001,0,2,3'b000));
        vt.push_back(mk(0,0,0,0,0,1001,0,3,3'b000));
        vt.push_back(mk(0,0,0,0,0,1001,0,0,3'b000));        // discarded request stays dead
        vt.push_back(mk(1,1,16'd0,8'h55,0,1001,0,1,3'b001)); // unknown mode acts as sync-idx
        vt.push_back(mk(0,0,0,0,0,1001,0,2,3'b001));
        vt.push_back(mk(0,0,0,0,0,1001,0,3,3'b001));
        vt.push_back(mk(0,0,0,0,0,1001,0,0,3'b100));
        vt.push_back(mk(0,0,0,0,0,1001,0,1,3'b100));
        vt.push_back(mk(0,0,0,0,0,1001,0,2,3'b100));
        vt.push_back(mk(0,0,0,0,0,1001,0,3,3'b100));
        vt.push_back(mk(0,0,0,0,0,1001,0,0,3'b110));

        // Reset state.
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset", {SEGMENT, STOP, BUSY}, 3'b000);
        RST = 1'b0;

        foreach (vt[i]) begin
            UPDATE_SETTINGS = vt[i].upd; REQ_RD_SEGMENT = vt[i].req; REP = vt[i].rep;
            TRANSITION_MODE = vt[i].mode; TRANSITION_VALUE = vt[i].val;
            SYS_TIME = vt[i].st; GPIO_IN = vt[i].gpio; IDX[1] = vt[i].idx1;
            cyc("model");
            check($sformatf("vec%0d", i), {SEGMENT, STOP, BUSY}, vt[i].exp);
        end
        UPDATE_SETTINGS = 1'b0;

        // Enter LOOPING on segment 1, then reset asynchronously mid-cycle.
        IDX[1] = 15'd1; GPIO_IN = '0;
        UPDATE_SETTINGS = 1'b1; REQ_RD_SEGMENT = 1'b1; REP = 16'hFFFE;
        TRANSITION_MODE = 8'h01; TRANSITION_VALUE = {8'h00, SYS_TIME};
        cyc("loop_req");
        UPDATE_SETTINGS = 1'b0;
        cyc("loop_start");
        check("loop_entry", {SEGMENT, STOP, BUSY}, 3'b100);
        #2 RST = 1'b1;
        #1 check("async_rst", {SEGMENT, STOP, BUSY}, 3'b000);
        model_reset();
        @(posedge CLK);
        #1 RST = 1'b0;
        IDX[1] = 15'd3;
        cyc("post_rst_a");
        IDX[1] = 15'd0;
        cyc("post_rst_wrap");
        check("post_rst_hold", {SEGMENT, STOP, BUSY}, 3'b000);

        // Random traffic against the model.
        SYS_TIME = 56'd2000;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                CYCLE[0] = 15'($urandom_range(0, 3));
                CYCLE[1] = 15'($urandom_range(0, 3));
            end
            for (int s = 0; s < 2; s++)
                if ($urandom_range(0, 1) == 1)
                    IDX[s] = (IDX[s] >= CYCLE[s]) ? 15'd0 : IDX[s] + 15'd1;
            SYS_TIME = SYS_TIME + 56'd1;
            GPIO_IN = 4'($urandom);
            UPDATE_SETTINGS = ($urandom_range(0, 11) == 0);
            REQ_RD_SEGMENT = 1'($urandom);
            REP = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom_range(0, 4));
            case ($urandom_range(0, 4))
                0: TRANSITION_MODE = 8'h00;
                1: TRANSITION_MODE = 8'h01;
                2: TRANSITION_MODE = 8'h02;
                3: TRANSITION_MODE = 8'hF0;
                default: TRANSITION_MODE = 8'($urandom);
            endcase
            TRANSITION_VALUE = {8'($urandom), SYS_TIME + 56'($urandom_range(0, 30))};
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
